// File: rtl/flexbex_ibex_efpga_ctrl.sv
// ---------------------------------------------------------------------------
// flexbex_ibex_efpga_ctrl
//
// Sequencer for the custom eFPGA instruction (opcode 0x0b). It sits between
// ID/EX and the eFPGA fabric port. When the decoder's eFPGA enable fires, it
// latches the operator, delay and operands, then fires a one-cycle strobe to
// the fabric. Completion comes in one of two ways:
//   - Fixed mode: wait an instruction-encoded number of cycles.
//   - Handshake mode (delay 0): wait for efpga_done_i, bounded by TIMEOUT.
// The result is returned with a one-cycle valid pulse. The EX stage is
// stalled for the whole operation.
//
// Parameters
//   TIMEOUT            max wait for efpga_done_i in handshake mode (>=1)
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   en_i               eFPGA instruction enable (held high while stalled)
//   operator_i         operator, instr[13:12]
//   delay_i            fixed latency, instr[28:25]; 0 = handshake mode
//   operand_a/b_i      rs1 / rs2 values
//   kill_i             pipeline flush, aborts any operation in flight
//   ready_o            EX ready (0 stalls the pipeline)
//   result_valid_o     one-cycle writeback pulse
//   result_o, error_o  captured result / handshake-timeout flag
//   busy_o             sequencer not idle
//   efpga_strobe_o     one-cycle operation start pulse to the fabric
//   efpga_operator_o, efpga_operand_a/b_o   latched operation to the fabric
//   efpga_result_i, efpga_done_i            fabric result / completion flag
// ---------------------------------------------------------------------------
module flexbex_ibex_efpga_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  operator_i,
    input  logic [3:0]  delay_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic        error_o,
    output logic        busy_o,
    output logic        efpga_strobe_o,
    output logic [1:0]  efpga_operator_o,
    output logic [31:0] efpga_operand_a_o,
    output logic [31:0] efpga_operand_b_o,
    input  logic [31:0] efpga_result_i,
    input  logic        efpga_done_i
);

    // The counter must hold both the 4-bit delay and TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         delay_q, delay_d;
    logic [1:0]         operator_q, operator_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic [31:0]        result_q, result_d;
    logic               error_q, error_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            delay_q    <= '0;
            operator_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            operator_q <= operator_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        operator_d = operator_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        error_d    = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    operator_d = operator_i;
                    delay_d    = delay_i;
                    op_a_d     = operand_a_i;
                    op_b_d     = operand_b_i;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d   = (delay_q == 4'd0) ? CNT_W'(TIMEOUT) : CNT_W'(delay_q);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (delay_q != 4'd0) begin
                    // Fixed latency: the fabric result is sampled blindly.
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = efpga_result_i;
                        error_d  = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    // Handshake: done is checked first, so it wins over a
                    // timeout that expires in the same cycle.
                    if (efpga_done_i) begin
                        result_d = efpga_result_i;
                        error_d  = 1'b0;
                        state_d  = S_DONE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                // en_i is deliberately not looked at here: it is still high
                // from the stalled instruction and must not restart it.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A flush drops the operation without touching the visible result
        // and, in IDLE, without latching a new one.
        if (kill_i) begin
            state_d    = S_IDLE;
            delay_d    = delay_q;
            operator_d = operator_q;
            op_a_d     = op_a_q;
            op_b_d     = op_b_q;
            result_d   = result_q;
            error_d    = error_q;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // An instruction arriving in IDLE stalls immediately, so ready depends
    // combinationally on en_i.
    assign ready_o           = ((state_q == S_IDLE) && !en_i) || (state_q == S_DONE);
    assign result_valid_o    = (state_q == S_DONE) && !kill_i;
    assign busy_o            = (state_q != S_IDLE);
    assign efpga_strobe_o    = (state_q == S_ISSUE);
    assign result_o          = result_q;
    assign error_o           = error_q;
    assign efpga_operator_o  = operator_q;
    assign efpga_operand_a_o = op_a_q;
    assign efpga_operand_b_o = op_b_q;

endmodule

// File: tb/tb_flexbex_ibex_efpga_ctrl.sv
module tb_flexbex_ibex_efpga_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [1:0]  operator_i;
    logic [3:0]  delay_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic        kill_i;
    logic        ready_o, result_valid_o, error_o, busy_o, efpga_strobe_o;
    logic [31:0] result_o;
    logic [1:0]  efpga_operator_o;
    logic [31:0] efpga_operand_a_o, efpga_operand_b_o;
    logic [31:0] efpga_result_i;
    logic        efpga_done_i;

    flexbex_ibex_efpga_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .en_i              (en_i),
        .operator_i        (operator_i),
        .delay_i           (delay_i),
        .operand_a_i       (operand_a_i),
        .operand_b_i       (operand_b_i),
        .kill_i            (kill_i),
        .ready_o           (ready_o),
        .result_valid_o    (result_valid_o),
        .result_o          (result_o),
        .error_o           (error_o),
        .busy_o            (busy_o),
        .efpga_strobe_o    (efpga_strobe_o),
        .efpga_operator_o  (efpga_operator_o),
        .efpga_operand_a_o (efpga_operand_a_o),
        .efpga_operand_b_o (efpga_operand_b_o),
        .efpga_result_i    (efpga_result_i),
        .efpga_done_i      (efpga_done_i)
    );

    always #5 clk_i = ~clk_i;

    // Cycle index: cycle N is the interval following the Nth rising edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (efpga_strobe_o) n_strobe++;
            if (result_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", cyc, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_cycle", cyc, e.cyc);
                    chk("sb_result", result_o, e.res);
                    chk("sb_error", error_o, e.err);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_en(input logic [1:0] op, input logic [3:0] d,
                            input logic [31:0] a, input logic [31:0] b);
        en_i        = 1'b1;
        operator_i  = op;
        delay_i     = d;
        operand_a_i = a;
        operand_b_i = b;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_strobe"}, efpga_strobe_o, 0);
        chk({tag, "_valid"}, result_valid_o, 0);
        chk({tag, "_error"}, error_o, 0);
        chk({tag, "_result"}, result_o, 0);
        chk({tag, "_operator"}, efpga_operator_o, 0);
        chk({tag, "_opa"}, efpga_operand_a_o, 0);
        chk({tag, "_opb"}, efpga_operand_b_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ready"}, ready_o, 1);
    endtask

    initial begin
        int c0;
        int s0;
        rst_i = 1'b1; en_i = 1'b0; operator_i = '0; delay_i = '0;
        operand_a_i = '0; operand_b_i = '0; kill_i = 1'b0;
        efpga_result_i = 32'h1111_1111; efpga_done_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_i);
        #2;
        check_reset_vals("rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        next_cycle();

        // ---------------- fixed delay D=3 ----------------
        c0 = cyc;
        drive_en(2'b01, 4'd3, 32'h12, 32'h34);
        exp_q.push_back('{c0 + 5, 32'hCAFE_0001, 1'b0});
        for (int i = 0; i <= 5; i++) begin
            if (i == 1) en_i = 1'b0;
            if (i == 4) efpga_result_i = 32'hCAFE_0001;
            @(negedge clk_i);
            chk($sformatf("fix_ready_c%0d", i), ready_o, (i == 5));
            chk($sformatf("fix_strobe_c%0d", i), efpga_strobe_o, (i == 1));
            if (i == 1) begin
                chk("fix_operator", efpga_operator_o, 2'b01);
                chk("fix_opa", efpga_operand_a_o, 32'h12);
                chk("fix_opb", efpga_operand_b_o, 32'h34);
            end
            next_cycle();
        end
        repeat (2) next_cycle();

        // ---------------- handshake, done in cycle 6 ----------------
        c0 = cyc;
        efpga_result_i = 32'h5555_5555;
        drive_en(2'b10, 4'd0, 32'hA, 32'hB);
        exp_q.push_back('{c0 + 7, 32'hDEAD_BEEF, 1'b0});
        for (int i = 1; i <= 9; i++) begin
            next_cycle();
            en_i = (i <= 6);
            efpga_done_i = (i == 6);
            if (i == 6) efpga_result_i = 32'hDEAD_BEEF;
        end
        efpga_done_i = 1'b0;

        // ---------------- handshake timeout ----------------
        c0 = cyc;
        efpga_result_i = 32'h7777_7777;
        drive_en(2'b11, 4'd0, 32'h1, 32'h2);
        exp_q.push_back('{c0 + TIMEOUT + 2, 32'h0, 1'b1});
        next_cycle();
        en_i = 1'b0;
        repeat (TIMEOUT + 3) next_cycle();
        chk("tmo_error_held", error_o, 1);

        // ---------------- kill in cycle 3 of D=10 ----------------
        c0 = cyc;
        efpga_result_i = 32'h9999_9999;
        drive_en(2'b00, 4'd10, 32'h3, 32'h4);
        next_cycle(); en_i = 1'b0;  // cycle 1
        next_cycle();               // cycle 2
        next_cycle(); kill_i = 1'b1; // cycle 3
        next_cycle(); kill_i = 1'b0; // cycle 4
        @(negedge clk_i);
        chk("kill_busy", busy_o, 0);
        chk("kill_ready", ready_o, 1);
        chk("kill_result", result_o, 0);
        chk("kill_error", error_o, 1);
        repeat (14) next_cycle();

        // ---------------- back-to-back D=1, en held through DONE ----------------
        s0 = n_strobe;
        c0 = cyc;
        efpga_result_i = 32'h0000_00A1;
        drive_en(2'b01, 4'd1, 32'h5, 32'h6);
        exp_q.push_back('{c0 + 3, 32'h0000_00A1, 1'b0});
        exp_q.push_back('{c0 + 7, 32'h0000_00B2, 1'b0});
        for (int i = 1; i <= 12; i++) begin
            next_cycle();
            if (i == 3) efpga_result_i = 32'h0000_00B2;
            if (i == 5) en_i = 1'b0;
        end
        chk("b2b_strobes", n_strobe - s0, 2);

        // ---------------- reset mid-operation ----------------
        drive_en(2'b10, 4'd10, 32'hFF, 32'hEE);
        next_cycle(); en_i = 1'b0;
        repeat (3) next_cycle();
        chk("rstmid_busy_before", busy_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_vals("rstmid");
        @(negedge clk_i);
        rst_i = 1'b0;
        next_cycle();
        c0 = cyc;
        efpga_result_i = 32'h1234_5678;
        drive_en(2'b11, 4'd2, 32'h7, 32'h8);
        exp_q.push_back('{c0 + 4, 32'h1234_5678, 1'b0});
        next_cycle(); en_i = 1'b0;
        repeat (8) next_cycle();

        // ---------------- drain ----------------
        chk("sb_drained", exp_q.size(), 0);
        chk("final_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
